ob_cn_mtr_merge: RTL and testbench
==================================

# ob_cn_mtr_merge

Merges matured conditional commands from the conditional table's maturity latch with the ingress command stream, and forwards one command per cycle to the order-book controller. Matured stop commands are rewritten into their issuable form (stop-loss to market, stop-limit to limit) before forwarding. A two-entry output buffer decouples both sources from controller back-pressure. A fairness counter prevents a burst of matured commands from starving ingress.

## Interface
Parameters:
- MTR_BURST, 4, maximum consecutive matured grants while ingress is pending; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_vld  in  1  ingress command valid.
- in_cmd  in  ob_pkg::cmd_t  ingress command.
- in_accept  out  1  ingress command consumed this cycle.
- mtr_vld_r  in  1  matured command valid, from the conditional table.
- mtr_r  in  ob_pkg::cmd_t  matured command.
- mtr_accept  out  1  matured command consumed this cycle.
- out_vld_r  out  1  head of output buffer valid.
- out_r  out  ob_pkg::cmd_t  head of output buffer.
- out_accept  in  1  controller consumes head this cycle.
- mtr_issued_cnt_r  out  16  count of matured commands forwarded; saturating.

## Operation
- Output buffer: 2-entry FIFO with occupancy occ_r in 0..2. Push and pop may occur in the same cycle.
- Pop: occurs when out_vld_r & out_accept.
- Grant eligibility: a grant is possible when occ_r < 2. A grant is not possible when occ_r == 2, even if a pop occurs that cycle. This keeps the accept outputs free of any combinational path from out_accept.
- Arbitration, when a grant is possible:
  - Only one source valid: grant it.
  - Both sources valid: grant matured, unless burst_r == MTR_BURST, in which case grant ingress.
- burst_r counter:
  - Increments on a matured grant while in_vld is high.
  - Clears on an ingress grant, or on any cycle with in_vld low.
  - Saturates at MTR_BURST.
- in_accept / mtr_accept: equal to the respective grant. At most one is high per cycle.
- Pushed payload:
  - Ingress grant: in_cmd, unchanged.
  - Matured grant: ob_pkg::cn_to_issue(mtr_r).
    - Stop-loss buy/sell becomes market buy/sell; price is zeroed.
    - Stop-limit buy/sell becomes limit buy/sell; price is kept.
    - All other opcodes pass through unchanged.
    - uid and quantity are always preserved.
- mtr_issued_cnt_r: increments on each matured grant and holds at 16'hFFFF.
- Ordering: commands leave in grant order.
- Cancel of a command in the maturity latch is handled upstream. If mtr_vld_r drops in the same cycle, no grant is issued for it.

## Timing
- Reset values: out_vld_r = 0, out_r = 0, occ_r = 0, burst_r = 0, mtr_issued_cnt_r = 0. in_accept and mtr_accept are 0 during the reset cycle.
- Latency: a command granted in cycle t is visible at out_r in cycle t+1 when the buffer was empty. Otherwise it appears after the older entry pops.
- Throughput: one command per cycle when out_accept is held high (occ_r stays at 1).
- in_accept and mtr_accept depend only on registered state and on in_vld / mtr_vld_r.
- Reset mid-operation: buffer contents are discarded, with no output in the reset cycle.
- Full buffer (occ_r == 2): both accepts are low. Ingress and matured commands hold their valid.

## Structure
- ob_pkg holds:
  - the cmd_t and opcode enums (existing);
  - the new function cn_to_issue(cmd_t) -> cmd_t;
  - the constant MTR_ISSUED_CNT_W = 16.
- One sub-module: ob_cmd_buf2, a generic 2-entry FIFO of cmd_t (push, pop, occ_r, head). The arbiter, rewrite and counters stay in the top level.

## Test plan
- Ingress only: in_vld with uid 0x10 and limit buy, out_accept held high -> in_accept in cycle 0; out_r.uid == 0x10 in cycle 1; the command is unmodified.
- Matured stop-loss: mtr_r is stop-loss sell, price 105, qty 7 -> out_r is market sell, price 0, qty 7; mtr_issued_cnt_r == 1.
- Fairness, MTR_BURST = 4, both sources continuously valid, out_accept high -> grant pattern is M, M, M, M, I, M, M, M, M, I.
- Back-pressure: out_accept low for 5 cycles with both sources valid -> exactly 2 grants, then both accepts low. After releasing out_accept, order is preserved and no command is lost or duplicated.
- Matured valid drops (upstream cancel) while the buffer is full -> no mtr_accept and no push. The next ingress command is forwarded normally.
- Reset asserted with occ_r == 2 -> out_vld_r == 0 the next cycle and counters cleared. mtr_issued_cnt_r preloaded near 0xFFFF saturates at 0xFFFF.

Source files
------------

// File: rtl/ob_pkg.sv
// Order-book shared types: command opcodes, the command record, and the
// conditional-to-issuable rewrite applied to matured stop commands.
package ob_pkg;

    typedef enum logic [3:0] {
        OP_NOP         = 4'd0,
        OP_LMT_BUY     = 4'd1,
        OP_LMT_SELL    = 4'd2,
        OP_MKT_BUY     = 4'd3,
        OP_MKT_SELL    = 4'd4,
        OP_STOP_BUY    = 4'd5,
        OP_STOP_SELL   = 4'd6,
        OP_STPLMT_BUY  = 4'd7,
        OP_STPLMT_SELL = 4'd8,
        OP_CANCEL      = 4'd9,
        OP_MODIFY      = 4'd10
    } opcode_t;

    typedef struct packed {
        opcode_t     op;
        logic [15:0] uid;
        logic [31:0] price;
        logic [15:0] qty;
    } cmd_t;

    localparam int MTR_ISSUED_CNT_W = 16;

    // Stop-loss becomes market (price no longer meaningful, so zeroed);
    // stop-limit becomes limit at its limit price. uid/qty always kept.
    function automatic cmd_t cn_to_issue(input cmd_t c);
        cmd_t r;
        r = c;
        case (c.op)
            OP_STOP_BUY: begin
                r.op    = OP_MKT_BUY;
                r.price = '0;
            end
            OP_STOP_SELL: begin
                r.op    = OP_MKT_SELL;
                r.price = '0;
            end
            OP_STPLMT_BUY:  r.op = OP_LMT_BUY;
            OP_STPLMT_SELL: r.op = OP_LMT_SELL;
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ob_cmd_buf2.sv
// Two-entry command FIFO. Entry 0 is always the head, so the head output
// is a plain register with no read-pointer mux.
module ob_cmd_buf2
    import ob_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  cmd_t       push_data,
    input  logic       pop,
    output logic [1:0] occ_r,
    output logic       head_vld,
    output cmd_t       head
);

    logic [1:0] occ_q, occ_d;
    cmd_t       ent0_q, ent0_d;
    cmd_t       ent1_q, ent1_d;
    logic       do_pop, do_push;

    // Shift on pop, fill the first free slot on push.
    always_comb begin
        occ_d   = occ_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        do_pop  = pop && (occ_q != 2'd0);
        do_push = push && ((occ_q != 2'd2) || do_pop);
        if (do_pop) begin
            ent0_d = ent1_q;
        end
        if (do_push) begin
            if ((occ_q == 2'd0) || ((occ_q == 2'd1) && do_pop)) begin
                ent0_d = push_data;
            end else begin
                ent1_d = push_data;
            end
        end
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= 2'd0;
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            occ_q  <= occ_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
        end
    end

    assign occ_r    = occ_q;
    assign head_vld = (occ_q != 2'd0);
    assign head     = ent0_q;

endmodule

// File: rtl/ob_cn_mtr_merge.sv
// Merges matured conditional commands with ingress commands into a single
// stream for the order-book controller, rewriting matured stops into their
// issuable form. A burst counter bounds how long ingress can be starved.
module ob_cn_mtr_merge
    import ob_pkg::*;
#(
    parameter int MTR_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_vld,
    input  cmd_t                        in_cmd,
    output logic                        in_accept,
    input  logic                        mtr_vld_r,
    input  cmd_t                        mtr_r,
    output logic                        mtr_accept,
    output logic                        out_vld_r,
    output cmd_t                        out_r,
    input  logic                        out_accept,
    output logic [MTR_ISSUED_CNT_W-1:0] mtr_issued_cnt_r
);

    localparam logic [3:0] BURST_MAX = 4'(MTR_BURST);
    localparam logic [MTR_ISSUED_CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]                  occ;
    logic                        can_grant;
    logic                        burst_hit;
    logic                        in_gnt, mtr_gnt;
    logic                        push;
    cmd_t                        push_data;
    logic [3:0]                  burst_q, burst_d;
    logic [MTR_ISSUED_CNT_W-1:0] cnt_q, cnt_d;

    // Arbitration. Eligibility looks only at registered occupancy (never at
    // out_accept), so a full buffer blocks grants even on a popping cycle.
    always_comb begin
        can_grant = (occ != 2'd2) && !rst;
        burst_hit = (burst_q == BURST_MAX);
        mtr_gnt   = can_grant && mtr_vld_r && (!in_vld || !burst_hit);
        in_gnt    = can_grant && in_vld && (!mtr_vld_r || burst_hit);
        push      = mtr_gnt || in_gnt;
        push_data = mtr_gnt ? cn_to_issue(mtr_r) : in_cmd;
    end

    // Fairness counter and saturating matured-issue counter.
    always_comb begin
        burst_d = burst_q;
        cnt_d   = cnt_q;
        if (!in_vld || in_gnt) begin
            burst_d = 4'd0;
        end else if (mtr_gnt && !burst_hit) begin
            burst_d = burst_q + 4'd1;
        end
        if (mtr_gnt && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_q <= 4'd0;
            cnt_q   <= '0;
        end else begin
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
        end
    end

    ob_cmd_buf2 u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (out_accept),
        .occ_r     (occ),
        .head_vld  (out_vld_r),
        .head      (out_r)
    );

    assign in_accept        = in_gnt;
    assign mtr_accept       = mtr_gnt;
    assign mtr_issued_cnt_r = cnt_q;

endmodule

// File: tb/tb_ob_cn_mtr_merge.sv
// Directed bench for ob_cn_mtr_merge with hand-computed expectations.
module tb_ob_cn_mtr_merge;
    import ob_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    cmd_t        in_cmd;
    logic        in_accept;
    logic        mtr_vld_r;
    cmd_t        mtr_r;
    logic        mtr_accept;
    logic        out_vld_r;
    cmd_t        out_r;
    logic        out_accept;
    logic [15:0] mtr_issued_cnt_r;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ob_cn_mtr_merge #(.MTR_BURST(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_vld           (in_vld),
        .in_cmd           (in_cmd),
        .in_accept        (in_accept),
        .mtr_vld_r        (mtr_vld_r),
        .mtr_r            (mtr_r),
        .mtr_accept       (mtr_accept),
        .out_vld_r        (out_vld_r),
        .out_r            (out_r),
        .out_accept       (out_accept),
        .mtr_issued_cnt_r (mtr_issued_cnt_r)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    function automatic cmd_t mk(input opcode_t op, input logic [15:0] uid,
                                input logic [31:0] price, input logic [15:0] qty);
        cmd_t c;
        c.op = op; c.uid = uid; c.price = price; c.qty = qty;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [9:0] exp_m;
        logic       m_now;
        rst = 1'b1; in_vld = 1'b0; in_cmd = '0; mtr_vld_r = 1'b0; mtr_r = '0; out_accept = 1'b0;

        // Reset state
        step(); step();
        in_vld = 1'b1; in_cmd = mk(OP_LMT_BUY, 16'h0001, 32'd1, 16'd1);
        settle();
        chk("rst_in_accept", 96'(in_accept), 96'd0);
        in_vld = 1'b0;
        step();
        rst = 1'b0;
        settle();
        chk("rst_out_vld", 96'(out_vld_r), 96'd0);
        chk("rst_out_r", 96'(out_r), 96'd0);
        chk("rst_cnt", 96'(mtr_issued_cnt_r), 96'd0);

        // Ingress only
        out_accept = 1'b1;
        in_vld = 1'b1; in_cmd = mk(OP_LMT_BUY, 16'h0010, 32'd100, 16'd5);
        settle();
        chk("ing_in_accept", 96'(in_accept), 96'd1);
        chk("ing_mtr_accept", 96'(mtr_accept), 96'd0);
        step();
        in_vld = 1'b0;
        chk("ing_out_vld", 96'(out_vld_r), 96'd1);
        chk("ing_out_r", 96'(out_r), 96'(mk(OP_LMT_BUY, 16'h0010, 32'd100, 16'd5)));
        step();
        chk("ing_drain", 96'(out_vld_r), 96'd0);

        // Matured stop-loss sell -> market sell, price zeroed
        mtr_vld_r = 1'b1; mtr_r = mk(OP_STOP_SELL, 16'h0021, 32'd105, 16'd7);
        settle();
        chk("sl_mtr_accept", 96'(mtr_accept), 96'd1);
        step();
        mtr_r = mk(OP_STPLMT_BUY, 16'h0022, 32'd77, 16'd9);
        chk("sl_out_r", 96'(out_r), 96'(mk(OP_MKT_SELL, 16'h0021, 32'd0, 16'd7)));
        chk("sl_cnt", 96'(mtr_issued_cnt_r), 96'd1);
        // Stop-limit buy -> limit buy, price kept
        step();
        mtr_r = mk(OP_CANCEL, 16'h0023, 32'd5, 16'd2);
        chk("stl_out_r", 96'(out_r), 96'(mk(OP_LMT_BUY, 16'h0022, 32'd77, 16'd9)));
        // Cancel passes unchanged
        step();
        mtr_vld_r = 1'b0;
        chk("cxl_out_r", 96'(out_r), 96'(mk(OP_CANCEL, 16'h0023, 32'd5, 16'd2)));
        chk("cxl_cnt", 96'(mtr_issued_cnt_r), 96'd3);
        step();
        chk("cxl_drain", 96'(out_vld_r), 96'd0);

        // Fairness: M M M M I M M M M I
        exp_m = 10'b1111011110;
        in_vld = 1'b1; in_cmd = mk(OP_LMT_SELL, 16'h0011, 32'd10, 16'd1);
        mtr_vld_r = 1'b1; mtr_r = mk(OP_STOP_BUY, 16'h0022, 32'd50, 16'd3);
        for (int i = 0; i < 10; i++) begin
            settle();
            m_now = exp_m[9-i];
            chk($sformatf("fair_m%0d", i), 96'(mtr_accept), 96'(m_now));
            chk($sformatf("fair_i%0d", i), 96'(in_accept), 96'(!m_now));
            step();
            chk($sformatf("fair_uid%0d", i), 96'(out_r.uid), m_now ? 96'h22 : 96'h11);
        end
        in_vld = 1'b0; mtr_vld_r = 1'b0;
        step();
        chk("fair_drain", 96'(out_vld_r), 96'd0);
        chk("fair_cnt", 96'(mtr_issued_cnt_r), 96'd11);

        // Back-pressure: exactly 2 grants then both accepts low
        out_accept = 1'b0;
        in_vld = 1'b1; in_cmd = mk(OP_LMT_BUY, 16'h0040, 32'd20, 16'd4);
        mtr_vld_r = 1'b1; mtr_r = mk(OP_STOP_BUY, 16'h0030, 32'd60, 16'd6);
        for (int j = 0; j < 5; j++) begin
            settle();
            chk($sformatf("bp_m%0d", j), 96'(mtr_accept), (j < 2) ? 96'd1 : 96'd0);
            chk($sformatf("bp_i%0d", j), 96'(in_accept), 96'd0);
            step();
            if (j == 0) mtr_r = mk(OP_STOP_BUY, 16'h0031, 32'd61, 16'd6);
            if (j == 1) mtr_r = mk(OP_STOP_BUY, 16'h0032, 32'd62, 16'd6);
        end
        mtr_vld_r = 1'b0; out_accept = 1'b1;
        settle();
        chk("bp_full_in_accept", 96'(in_accept), 96'd0);
        chk("bp_head0", 96'(out_r), 96'(mk(OP_MKT_BUY, 16'h0030, 32'd0, 16'd6)));
        step();
        settle();
        chk("bp_in_accept", 96'(in_accept), 96'd1);
        chk("bp_head1", 96'(out_r.uid), 96'h31);
        step();
        in_vld = 1'b0;
        chk("bp_head2", 96'(out_r), 96'(mk(OP_LMT_BUY, 16'h0040, 32'd20, 16'd4)));
        step();
        chk("bp_drain", 96'(out_vld_r), 96'd0);
        chk("bp_cnt", 96'(mtr_issued_cnt_r), 96'd13);

        // Upstream cancel of matured command while full
        out_accept = 1'b0;
        in_vld = 1'b1; in_cmd = mk(OP_LMT_BUY, 16'h0050, 32'd1, 16'd1);
        step();
        in_cmd = mk(OP_LMT_BUY, 16'h0051, 32'd1, 16'd1);
        step();
        in_vld = 1'b0;
        mtr_vld_r = 1'b1; mtr_r = mk(OP_STOP_SELL, 16'h0060, 32'd9, 16'd9);
        settle();
        chk("cx_mtr_accept", 96'(mtr_accept), 96'd0);
        step();
        mtr_vld_r = 1'b0;
        in_vld = 1'b1; in_cmd = mk(OP_LMT_SELL, 16'h0052, 32'd3, 16'd3);
        out_accept = 1'b1;
        settle();
        chk("cx_full_in_accept", 96'(in_accept), 96'd0);
        chk("cx_head0", 96'(out_r.uid), 96'h50);
        step();
        settle();
        chk("cx_in_accept", 96'(in_accept), 96'd1);
        chk("cx_head1", 96'(out_r.uid), 96'h51);
        step();
        in_vld = 1'b0;
        chk("cx_head2", 96'(out_r), 96'(mk(OP_LMT_SELL, 16'h0052, 32'd3, 16'd3)));
        step();
        chk("cx_drain", 96'(out_vld_r), 96'd0);
        chk("cx_cnt", 96'(mtr_issued_cnt_r), 96'd13);

        // Reset while full
        out_accept = 1'b0;
        in_vld = 1'b1; in_cmd = mk(OP_LMT_BUY, 16'h0070, 32'd1, 16'd1);
        step();
        in_cmd = mk(OP_LMT_BUY, 16'h0071, 32'd1, 16'd1);
        step();
        chk("rf_full_vld", 96'(out_vld_r), 96'd1);
        rst = 1'b1;
        settle();
        chk("rf_in_accept", 96'(in_accept), 96'd0);
        step();
        rst = 1'b0; in_vld = 1'b0;
        chk("rf_out_vld", 96'(out_vld_r), 96'd0);
        chk("rf_out_r", 96'(out_r), 96'd0);
        chk("rf_cnt", 96'(mtr_issued_cnt_r), 96'd0);

        // Counter saturation: continuous matured stop-limit sells
        out_accept = 1'b1;
        mtr_vld_r = 1'b1; mtr_r = mk(OP_STPLMT_SELL, 16'h0080, 32'd200, 16'd8);
        for (int k = 0; k < 65534; k++) step();
        chk("sat_fffe", 96'(mtr_issued_cnt_r), 96'hFFFE);
        chk("sat_rewrite", 96'(out_r), 96'(mk(OP_LMT_SELL, 16'h0080, 32'd200, 16'd8)));
        step();
        chk("sat_ffff", 96'(mtr_issued_cnt_r), 96'hFFFF);
        step(); step(); step();
        chk("sat_hold", 96'(mtr_issued_cnt_r), 96'hFFFF);
        mtr_vld_r = 1'b0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
